// File: rtl/fetch_pkg.sv
// Shared constants, fetch-buffer entry layout and sequencer state type.
package fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam int unsigned FETCH_W        = 96;

  // Entry layout: {instr, pc, pc4}
  localparam int unsigned INSTR_LSB = 64;
  localparam int unsigned PC_LSB    = 32;
  localparam int unsigned PC4_LSB   = 0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH x W storage with synchronous clear and a zeroed head when empty.
module fetch_fifo #(
  parameter int unsigned W     = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  output logic [W-1:0]             o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_FULL);
  assign o_count = r_count;
  assign w_pop   = i_pop && !o_empty;
  // A pop frees the slot the same edge, so a full buffer still accepts a push.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_dout  = o_empty ? '0 : r_mem[r_rd];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter, imem fetch issue, epoch-tagged response capture and decode handshake.
module pc_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        CLK,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_taken,
  input  logic [31:0] jmp_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  fetch_state_e        r_state;
  fetch_state_e        w_state_next;
  logic [31:0]         r_pc;
  logic [31:0]         r_ipc;
  logic                r_epoch;
  logic                r_tag;
  logic                r_inflight;
  logic                r_reset_q;

  logic                w_redirect;
  logic [31:0]         w_sel_target;
  logic [31:0]         w_target;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  logic [CW-1:0]       w_occ;
  logic [FETCH_W-1:0]  w_din;
  logic [FETCH_W-1:0]  w_dout;

  assign w_redirect   = br_taken | jmp_taken;
  assign w_sel_target = jmp_taken ? jmp_target : br_target;
  assign w_target     = {w_sel_target[31:2], 2'b00};

  // Occupancy counts the in-flight fetch so a response always has a free slot.
  assign w_occ     = w_count + CW'(r_inflight);
  assign imem_req  = !r_reset_q && !w_redirect && !w_full && (w_occ < CNT_DEPTH);
  assign imem_addr = r_pc;

  // FLUSH blocks any response issued before the redirect; the epoch tag covers the rest.
  assign w_push = r_inflight && (r_tag == r_epoch) && (r_state == ST_RUN);
  assign w_pop  = out_valid && out_ready && !w_redirect;

  always_comb begin
    w_din = '0;
    w_din[INSTR_LSB +: 32] = imem_rdata;
    w_din[PC_LSB    +: 32] = r_ipc;
    w_din[PC4_LSB   +: 32] = r_ipc + 32'd4;
  end

  fetch_fifo #(
    .W     (FETCH_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst   (reset),
    .i_clear (w_redirect),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign out_valid = !w_empty;
  assign out_instr = w_dout[INSTR_LSB +: 32];
  assign out_pc    = w_dout[PC_LSB    +: 32];
  assign out_pc4   = w_dout[PC4_LSB   +: 32];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (w_redirect) w_state_next = ST_FLUSH;
      ST_FLUSH: w_state_next = w_redirect ? ST_FLUSH : ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_ipc      <= '0;
      r_epoch    <= 1'b0;
      r_tag      <= 1'b0;
      r_inflight <= 1'b0;
      r_reset_q  <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_reset_q  <= 1'b0;
      r_inflight <= imem_req;
      if (imem_req) begin
        r_tag <= r_epoch;
        r_ipc <= r_pc;
      end
      if (w_redirect) begin
        r_pc    <= w_target;
        r_epoch <= ~r_epoch;
      end else if (imem_req) begin
        r_pc <= r_pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench: directed vector table, corner sequences and randomized run vs a queue model.
module tb_pc_fetch_sequencer;

  localparam int unsigned DEPTH     = 4;
  localparam logic [31:0] RPC       = 32'h0000_0000;
  localparam logic [31:0] RPC2      = 32'hFFFF_FFF8;
  localparam logic [31:0] IMEM_BASE = 32'h1000_0000;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        reset = 1'b1;
  logic        out_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic        jmp_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] jmp_target = '0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] imem_rdata2 = '0;

  logic        imem_req, out_valid;
  logic [31:0] imem_addr, out_instr, out_pc, out_pc4;
  logic        imem_req2, out_valid2;
  logic [31:0] imem_addr2, out_instr2, out_pc2, out_pc4_2;

  pc_fetch_sequencer #(.RESET_PC(RPC), .DEPTH(DEPTH)) u_dut (
    .CLK(CLK), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .br_taken(br_taken), .br_target(br_target),
    .jmp_taken(jmp_taken), .jmp_target(jmp_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .out_pc4(out_pc4)
  );

  pc_fetch_sequencer #(.RESET_PC(RPC2), .DEPTH(DEPTH)) u_dut2 (
    .CLK(CLK), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .br_taken(1'b0), .br_target(32'h0),
    .jmp_taken(1'b0), .jmp_target(32'h0), .out_valid(out_valid2),
    .out_ready(1'b1), .out_instr(out_instr2), .out_pc(out_pc2), .out_pc4(out_pc4_2)
  );

  int errors = 0;
  int n_checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered fetches plus one in-flight slot.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc = RPC;
  logic        m_epoch = 1'b0;
  logic        m_resetq = 1'b1;
  logic        m_inf = 1'b0;
  logic [31:0] m_inf_pc = '0;
  logic        m_inf_ep = 1'b0;
  logic        m_armed = 1'b0;
  logic [31:0] pend = '0;
  logic [31:0] pend2 = '0;

  function automatic logic m_req();
    int occ;
    occ = m_q.size() + (m_inf ? 1 : 0);
    return !m_resetq && !(br_taken || jmp_taken) && (occ < int'(DEPTH));
  endfunction

  task automatic check_model();
    if (!m_armed) return;
    chk("m_req",   {31'b0, imem_req},  {31'b0, m_req()});
    chk("m_addr",  imem_addr,          m_pc);
    chk("m_valid", {31'b0, out_valid}, {31'b0, (m_q.size() > 0)});
    if (m_q.size() > 0) begin
      chk("m_pc",    out_pc,    m_q[0].pc);
      chk("m_pc4",   out_pc4,   m_q[0].pc4);
      chk("m_instr", out_instr, m_q[0].instr);
    end
  endtask

  task automatic model_step();
    logic        req;
    logic        redir;
    logic [31:0] old_pc;
    logic        old_ep;
    req    = m_req();
    redir  = br_taken || jmp_taken;
    old_pc = m_pc;
    old_ep = m_epoch;
    if (reset) begin
      m_pc = RPC; m_q.delete(); m_inf = 1'b0; m_epoch = 1'b0; m_resetq = 1'b1; m_armed = 1'b1;
    end else begin
      if (!redir) begin
        if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
        if (m_inf && m_inf_ep == m_epoch)
          m_q.push_back(ent_t'{IMEM_BASE + m_inf_pc, m_inf_pc, m_inf_pc + 32'd4});
        if (req) m_pc = m_pc + 32'd4;
      end else begin
        m_q.delete();
        m_pc = (jmp_taken ? jmp_target : br_target) & ~32'h3;
        m_epoch = ~m_epoch;
      end
      m_inf = req; m_inf_pc = old_pc; m_inf_ep = old_ep; m_resetq = 1'b0;
    end
  endtask

  task automatic apply(input logic rst, input logic rdy, input logic br, input logic [31:0] bt,
                       input logic jmp, input logic [31:0] jt);
    reset = rst; out_ready = rdy; br_taken = br; br_target = bt; jmp_taken = jmp; jmp_target = jt;
    @(negedge CLK);
    check_model();
  endtask

  task automatic advance();
    model_step();
    pend  = imem_addr;
    pend2 = imem_addr2;
    @(posedge CLK);
    #1;
    imem_rdata  = IMEM_BASE + pend;
    imem_rdata2 = IMEM_BASE + pend2;
  endtask

  task automatic tick(input logic rst, input logic rdy);
    apply(rst, rdy, 1'b0, 32'h0, 1'b0, 32'h0);
    advance();
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic rst, logic rdy, logic c, logic rq, logic [31:0] a,
                              logic v, logic [31:0] p);
    tbl.push_back(vec_t'{rst, rdy, c, rq, a, v, p});
  endfunction

  initial begin
    logic [31:0] addrs2[$];
    logic        found;
    logic        rst_r, rdy_r, br_r, jmp_r;

    // Reset release with decode always ready: 1 instr/cycle after two-cycle latency.
    add(1, 1, 0, 0, 32'h00, 0, 32'h0);
    add(1, 1, 1, 0, 32'h00, 0, 32'h0);
    add(0, 1, 1, 0, 32'h00, 0, 32'h0);
    add(0, 1, 1, 1, 32'h00, 0, 32'h0);
    add(0, 1, 1, 1, 32'h04, 0, 32'h0);
    add(0, 1, 1, 1, 32'h08, 1, 32'h0);
    add(0, 1, 1, 1, 32'h0C, 1, 32'h4);
    add(0, 1, 1, 1, 32'h10, 1, 32'h8);
    // Back-pressure: buffer fills to DEPTH, issue stops, head holds, then drains in order.
    add(1, 0, 0, 0, 32'h00, 0, 32'h0);
    add(1, 0, 1, 0, 32'h00, 0, 32'h0);
    add(0, 0, 1, 0, 32'h00, 0, 32'h0);
    add(0, 0, 1, 1, 32'h00, 0, 32'h0);
    add(0, 0, 1, 1, 32'h04, 0, 32'h0);
    add(0, 0, 1, 1, 32'h08, 1, 32'h0);
    add(0, 0, 1, 1, 32'h0C, 1, 32'h0);
    add(0, 0, 1, 0, 32'h10, 1, 32'h0);
    add(0, 0, 1, 0, 32'h10, 1, 32'h0);
    add(0, 0, 1, 0, 32'h10, 1, 32'h0);
    add(0, 1, 1, 0, 32'h10, 1, 32'h0);
    add(0, 1, 1, 1, 32'h10, 1, 32'h4);
    add(0, 1, 1, 1, 32'h14, 1, 32'h8);
    add(0, 1, 1, 1, 32'h18, 1, 32'hC);
    add(0, 1, 1, 1, 32'h1C, 1, 32'h10);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].rdy, 1'b0, 32'h0, 1'b0, 32'h0);
      if (tbl[i].chk) begin
        chk($sformatf("v%0d_req", i),   {31'b0, imem_req},  {31'b0, tbl[i].req});
        chk($sformatf("v%0d_addr", i),  imem_addr,          tbl[i].addr);
        chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].valid});
        if (tbl[i].valid) begin
          chk($sformatf("v%0d_pc", i),    out_pc,    tbl[i].pc);
          chk($sformatf("v%0d_pc4", i),   out_pc4,   tbl[i].pc + 32'd4);
          chk($sformatf("v%0d_instr", i), out_instr, IMEM_BASE + tbl[i].pc);
        end
      end
      advance();
    end

    // Branch while 3 entries are buffered and one fetch is in flight.
    tick(1, 0); tick(1, 0);
    for (int i = 0; i < 5; i++) tick(0, 0);
    apply(0, 0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
    chk("br_req_blocked", {31'b0, imem_req}, 32'h0);
    advance();
    apply(0, 1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("br_flushed_valid", {31'b0, out_valid}, 32'h0);
    chk("br_fetch_addr", imem_addr, 32'h0000_0040);
    advance();
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      apply(0, 1, 1'b0, 32'h0, 1'b0, 32'h0);
      if (out_valid) begin
        chk("br_first_pc", out_pc, 32'h0000_0040);
        found = 1'b1;
      end
      advance();
    end
    chk("br_first_seen", {31'b0, found}, 32'h1);

    // Jump wins over branch; low target bits are dropped.
    apply(0, 1, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0203);
    advance();
    apply(0, 1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("jmp_addr", imem_addr, 32'h0000_0200);
    chk("jmp_req", {31'b0, imem_req}, 32'h1);
    advance();
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      apply(0, 1, 1'b0, 32'h0, 1'b0, 32'h0);
      if (out_valid) begin
        chk("jmp_first_pc", out_pc, 32'h0000_0200);
        found = 1'b1;
      end
      advance();
    end
    chk("jmp_first_seen", {31'b0, found}, 32'h1);

    // Second instance starts near the top of the address space and wraps.
    tick(1, 1); tick(1, 1);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      apply(0, 1, 1'b0, 32'h0, 1'b0, 32'h0);
      if (imem_req2) addrs2.push_back(imem_addr2);
      if (out_valid2 && out_pc2 == 32'hFFFF_FFFC) begin
        chk("wrap_pc4", out_pc4_2, 32'h0000_0000);
        found = 1'b1;
      end
      advance();
    end
    chk("wrap_nreq_ge3", {31'b0, (addrs2.size() >= 3)}, 32'h1);
    if (addrs2.size() >= 3) begin
      chk("wrap_a0", addrs2[0], 32'hFFFF_FFF8);
      chk("wrap_a1", addrs2[1], 32'hFFFF_FFFC);
      chk("wrap_a2", addrs2[2], 32'h0000_0000);
    end
    chk("wrap_pc4_seen", {31'b0, found}, 32'h1);

    // Reset with 2 buffered entries and 1 fetch in flight.
    tick(1, 0); tick(1, 0);
    for (int i = 0; i < 4; i++) tick(0, 0);
    apply(1, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    advance();
    apply(1, 0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_addr", imem_addr, RPC);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_pc4", out_pc4, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    advance();
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      apply(0, 1, 1'b0, 32'h0, 1'b0, 32'h0);
      if (out_valid) begin
        chk("rst_first_pc", out_pc, RPC);
        chk("rst_first_instr", out_instr, IMEM_BASE + RPC);
        found = 1'b1;
      end
      advance();
    end
    chk("rst_first_seen", {31'b0, found}, 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rst_r = ($urandom_range(99) == 0);
      rdy_r = ($urandom_range(9) < 7);
      br_r  = ($urandom_range(15) == 0);
      jmp_r = ($urandom_range(19) == 0);
      apply(rst_r, rdy_r, br_r, $urandom, jmp_r, $urandom);
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
